alu_responder: RTL and testbench

Pipelined request/response front end for the 32-bit ALU datapath. Accepts operand/opcode requests over a valid/ready handshake, evaluates them with the same opcode map as the combinational ALU, and returns results with flags through a buffered valid/ready response port in request order. The block is the responder-side counterpart to ALU stimulus/checker logic, and sits between an issuing controller and any consumer of ALU results.

---
 rtl/alu_responder.sv | 134 +++++++++++++
 tb/tb_alu_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_responder.sv
// Pipelined valid/ready front end for the 32-bit ALU: a one-entry operand stage (E)
// feeds a DEPTH-entry result FIFO that is drained in request order.
module alu_responder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_bad_op,
  output logic [15:0] rsp_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] OCC_MAX = (CW + 1)'(DEPTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic          e_valid_reg;
  logic [31:0]   e_a_reg;
  logic [31:0]   e_b_reg;
  logic [2:0]    e_op_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] fifo_count_reg;
  logic [15:0]   rsp_count_reg;

  // Each entry is {z, zero, ovf, bad_op}
  logic [34:0]   fifo_mem [DEPTH];
  logic [34:0]   head;

  logic [31:0]   alu_z;
  logic          alu_zero;
  logic          alu_ovf;
  logic          alu_bad;
  logic [31:0]   sum;
  logic [31:0]   diff;

  logic          fifo_full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  // Ready is a function of registered occupancy only, never of req_valid or rsp_ready
  assign occupancy = {{CW{1'b0}}, e_valid_reg} + {1'b0, fifo_count_reg};
  assign req_ready = occupancy < OCC_MAX;
  assign fifo_full = fifo_count_reg == CW'(DEPTH);
  assign rsp_valid = fifo_count_reg != '0;
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = e_valid_reg & (~fifo_full | pop);

  assign sum  = e_a_reg + e_b_reg;
  assign diff = e_a_reg - e_b_reg;

  always_comb begin
    alu_z   = '0;
    alu_ovf = 1'b0;
    alu_bad = 1'b0;
    case (e_op_reg)
      OP_AND: alu_z = e_a_reg & e_b_reg;
      OP_OR:  alu_z = e_a_reg | e_b_reg;
      OP_ADD: begin
        alu_z   = sum;
        alu_ovf = (e_a_reg[31] == e_b_reg[31]) && (sum[31] != e_a_reg[31]);
      end
      OP_SUB: begin
        alu_z   = diff;
        alu_ovf = (e_a_reg[31] != e_b_reg[31]) && (diff[31] != e_a_reg[31]);
      end
      OP_SLT: alu_z = {31'b0, $signed(e_a_reg) < $signed(e_b_reg)};
      default: alu_bad = 1'b1;
    endcase
    alu_zero = alu_z == '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_reg    <= 1'b0;
      e_a_reg        <= '0;
      e_b_reg        <= '0;
      e_op_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      rsp_count_reg  <= '0;
    end else begin
      // E is always empty or draining whenever accept is possible
      if (accept) begin
        e_valid_reg <= 1'b1;
        e_a_reg     <= req_a;
        e_b_reg     <= req_b;
        e_op_reg    <= req_op;
      end else if (push) begin
        e_valid_reg <= 1'b0;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (pop) rsp_count_reg <= rsp_count_reg + 16'd1;
    end
  end

  // Storage needs no reset: it is only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {alu_z, alu_zero, alu_ovf, alu_bad};
  end

  assign head       = fifo_mem[rd_ptr_reg];
  assign rsp_z      = rsp_valid ? head[34:3] : 32'd0;
  assign rsp_zero   = rsp_valid & head[2];
  assign rsp_ovf    = rsp_valid & head[1];
  assign rsp_bad_op = rsp_valid & head[0];
  assign rsp_count  = rsp_count_reg;

endmodule

// File: tb/tb_alu_responder.sv
// Directed bench for alu_responder: opcode vectors, latency, backpressure,
// randomised push/pop against a golden ALU model, and asynchronous reset mid-burst.
module tb_alu_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_bad_op;
  logic [15:0] rsp_count;

  alu_responder #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_bad_op(rsp_bad_op),
    .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] z;
    logic        zero;
    logic        ovf;
    logic        bad;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  function automatic exp_t mk(input logic [31:0] z, input logic zero, input logic ovf, input logic bad);
    return exp_t'({z, zero, ovf, bad});
  endfunction

  function automatic exp_t alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] z;
    logic        ovf;
    logic        bad;
    z = 32'd0; ovf = 1'b0; bad = 1'b0;
    case (op)
      3'b000: z = a & b;
      3'b001: z = a | b;
      3'b010: begin z = a + b; ovf = (a[31] == b[31]) && (z[31] != a[31]); end
      3'b110: begin z = a - b; ovf = (a[31] != b[31]) && (z[31] != a[31]); end
      3'b111: z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: bad = 1'b1;
    endcase
    return mk(z, z == 32'd0, ovf, bad);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; account for the accept and pop that occur at the next edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input exp_t e, input logic rr, output logic acc);
    exp_t h;
    req_valid = v; req_a = a; req_b = b; req_op = op; rsp_ready = rr;
    acc = v & req_ready;
    if (rsp_valid && rr) begin
      if (expq.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        h = expq.pop_front();
        pops++;
        $display("rsp %0d: z=0x%08h zero=%0b ovf=%0b bad_op=%0b", pops, rsp_z, rsp_zero, rsp_ovf, rsp_bad_op);
        chk("rsp_z", rsp_z, h.z);
        chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, h.zero});
        chk("rsp_ovf", {31'b0, rsp_ovf}, {31'b0, h.ovf});
        chk("rsp_bad_op", {31'b0, rsp_bad_op}, {31'b0, h.bad});
      end
    end
    if (acc) expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req_valid = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic        acc;
    int          idx;
    int          sent;
    logic [31:0] ca;
    logic [31:0] cb;
    logic [2:0]  cop;
    logic [2:0]  ops [5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_z", rsp_z, 32'd0);
    chk("reset_flags", {29'b0, rsp_zero, rsp_ovf, rsp_bad_op}, 32'd0);
    chk("reset_count", {16'b0, rsp_count}, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // AND then OR, checking two-edge latency
    step(1'b1, 32'h0000000F, 32'h00000003, 3'b000, mk(32'h3, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    chk("and_accepted", {31'b0, acc}, 32'd1);
    chk("latency_e_only", {31'b0, rsp_valid}, 32'd0);
    step(1'b1, 32'h0000000F, 32'h00000003, 3'b001, mk(32'hF, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    chk("latency_valid", {31'b0, rsp_valid}, 32'd1);
    chk("latency_head", rsp_z, 32'h3);
    step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    chk("andor_count", {16'b0, rsp_count}, 32'd2);
    chk("andor_drained", {31'b0, rsp_valid}, 32'd0);

    // Arithmetic, SLT and bad-op vectors issued back to back
    step(1'b1, 32'h7FFFFFFF, 32'h00000001, 3'b010, mk(32'h80000000, 1'b0, 1'b1, 1'b0), 1'b1, acc);
    step(1'b1, 32'h00000005, 32'h00000005, 3'b110, mk(32'h00000000, 1'b1, 1'b0, 1'b0), 1'b1, acc);
    chk("throughput_acc", {31'b0, acc}, 32'd1);
    step(1'b1, 32'h80000000, 32'h00000001, 3'b110, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0), 1'b1, acc);
    step(1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b111, mk(32'h00000001, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    step(1'b1, 32'h00000001, 32'hFFFFFFFF, 3'b111, mk(32'h00000000, 1'b1, 1'b0, 1'b0), 1'b1, acc);
    step(1'b1, 32'h00001234, 32'h00005678, 3'b011, mk(32'h00000000, 1'b1, 1'b0, 1'b1), 1'b1, acc);
    chk("throughput_acc_last", {31'b0, acc}, 32'd1);
    for (int c = 0; c < 3; c++)
      step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    chk("vectors_count", {16'b0, rsp_count}, 32'd8);
    chk("vectors_queue", expq.size(), 32'd0);

    // Backpressure: only DEPTH+1 requests fit while the consumer stalls
    reset_dut();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 32'(idx), 32'h10, 3'b010, mk(32'(idx) + 32'h10, 1'b0, 1'b0, 1'b0), 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 32'd3);
    chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    chk("bp_head_stable", rsp_z, 32'h10);
    for (int c = 0; c < 20 && (idx < 5 || expq.size() != 0); c++) begin
      step(idx < 5, 32'(idx), 32'h10, 3'b010, mk(32'(idx) + 32'h10, 1'b0, 1'b0, 1'b0), 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 32'd5);
    chk("bp_count", {16'b0, rsp_count}, 32'd5);
    chk("bp_queue", expq.size(), 32'd0);

    // Random traffic against the golden model
    reset_dut();
    sent = 0;
    ca = $urandom; cb = $urandom; cop = ops[$urandom_range(0, 4)];
    for (int c = 0; c < 3000 && (sent < 100 || expq.size() != 0); c++) begin
      step((sent < 100) && ($urandom_range(0, 4) != 0), ca, cb, cop, alu_model(ca, cb, cop),
           $urandom_range(0, 2) != 0, acc);
      if (acc) begin
        sent++;
        ca = ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom;
        cb = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
        cop = ops[$urandom_range(0, 4)];
      end
    end
    chk("rand_sent", sent, 32'd100);
    chk("rand_count", {16'b0, rsp_count}, 32'd100);
    chk("rand_queue", expq.size(), 32'd0);

    // Asynchronous reset with two entries in flight
    step(1'b1, 32'h1, 32'h1, 3'b010, mk(32'h2, 1'b0, 1'b0, 1'b0), 1'b0, acc);
    step(1'b1, 32'h3, 32'h3, 3'b010, mk(32'h6, 1'b0, 1'b0, 1'b0), 1'b0, acc);
    step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b0, acc);
    chk("inflight_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_req_ready", {31'b0, req_ready}, 32'd1);
    chk("async_count", {16'b0, rsp_count}, 32'd0);
    expq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 32'h1, 32'h2, 3'b010, mk(32'h3, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    step(1'b0, 32'h0, 32'h0, 3'b000, mk(32'h0, 1'b0, 1'b0, 1'b0), 1'b1, acc);
    chk("post_reset_count", {16'b0, rsp_count}, 32'd1);
    chk("post_reset_queue", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
